// File: rtl/sr_lock_arbiter.sv
// Round-robin mutual-exclusion arbiter driving a shared set/reset lock flag.
// A hold-time watchdog forces release of an owner that keeps the lock too long.
module sr_lock_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         rel,
    output logic [N-1:0]         gnt,
    output logic                 lock_q,
    output logic                 lock_qbar,
    output logic [$clog2(N)-1:0] owner,
    output logic                 timeout
);

    localparam int OW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [OW-1:0]   ptr_r;
    logic [CW-1:0]   cnt_r;

    logic [N-1:0]    gnt_nxt_s;
    logic            lock_nxt_s;
    logic [OW-1:0]   owner_nxt_s;
    logic [OW-1:0]   ptr_nxt_s;
    logic [CW-1:0]   cnt_nxt_s;
    logic            timeout_nxt_s;

    logic            win_found_s;
    logic [OW-1:0]   win_idx_s;
    logic [OW-1:0]   cand_s;
    logic            release_s;
    logic            expire_s;

    assign release_s = rel[owner];
    assign expire_s  = (cnt_r == CW'(TIMEOUT - 1));

    // Round-robin search starting just above the last owner, wrapping modulo N.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int i = 1; i <= N; i++) begin
            cand_s = OW'((int'(ptr_r) + i) % N);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    state_nxt_s = HELD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HELD: begin
                if (release_s || expire_s) begin
                    state_nxt_s = GAP;
                end else begin
                    state_nxt_s = HELD;
                end
            end
            GAP:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output logic: next values for the registered outputs and datapath.
    always_comb begin
        gnt_nxt_s     = gnt;
        lock_nxt_s    = lock_q;
        owner_nxt_s   = owner;
        ptr_nxt_s     = ptr_r;
        cnt_nxt_s     = cnt_r;
        timeout_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    gnt_nxt_s            = '0;
                    gnt_nxt_s[win_idx_s] = 1'b1;
                    lock_nxt_s           = 1'b1;
                    owner_nxt_s          = win_idx_s;
                    ptr_nxt_s            = win_idx_s;
                    cnt_nxt_s            = '0;
                end else begin
                    gnt_nxt_s  = '0;
                    lock_nxt_s = 1'b0;
                end
            end
            HELD: begin
                if (release_s) begin
                    gnt_nxt_s  = '0;
                    lock_nxt_s = 1'b0;
                end else if (expire_s) begin
                    gnt_nxt_s     = '0;
                    lock_nxt_s    = 1'b0;
                    timeout_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            GAP: begin
                gnt_nxt_s  = '0;
                lock_nxt_s = 1'b0;
            end
            default: begin
                gnt_nxt_s  = '0;
                lock_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered outputs and datapath; the pointer starts at N-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            lock_q    <= 1'b0;
            lock_qbar <= 1'b1;
            owner     <= '0;
            timeout   <= 1'b0;
            ptr_r     <= OW'(N - 1);
            cnt_r     <= '0;
        end else begin
            gnt       <= gnt_nxt_s;
            lock_q    <= lock_nxt_s;
            lock_qbar <= ~lock_nxt_s;
            owner     <= owner_nxt_s;
            timeout   <= timeout_nxt_s;
            ptr_r     <= ptr_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_sr_lock_arbiter.sv
// Directed and randomized bench for sr_lock_arbiter against an ownership-level reference model.
module tb_sr_lock_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] rel;
    logic [N-1:0] gnt;
    logic         lock_q;
    logic         lock_qbar;
    logic [1:0]   owner;
    logic         timeout;

    int checks;
    int errors;

    // Reference model: who holds the lock, for how many cycles, and whether a gap cycle is pending.
    bit m_held;
    bit m_gap;
    bit m_to;
    int m_owner;
    int m_ptr;
    int m_hold;

    sr_lock_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .lock_q    (lock_q),
        .lock_qbar (lock_qbar),
        .owner     (owner),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held  = 1'b0;
        m_gap   = 1'b0;
        m_to    = 1'b0;
        m_owner = 0;
        m_ptr   = N - 1;
        m_hold  = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] l);
        bit found;
        int w;
        m_to = 1'b0;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_held) begin
            if (l[m_owner]) begin
                m_held = 1'b0;
                m_gap  = 1'b1;
            end else if (m_hold == TIMEOUT) begin
                m_held = 1'b0;
                m_gap  = 1'b1;
                m_to   = 1'b1;
            end else begin
                m_hold++;
            end
        end else if (r != '0) begin
            found = 1'b0;
            for (int j = 1; j <= N; j++) begin
                w = (m_ptr + j) % N;
                if (!found && r[w]) begin
                    found   = 1'b1;
                    m_owner = w;
                end
            end
            m_ptr  = m_owner;
            m_held = 1'b1;
            m_hold = 1;
        end
    endtask

    task automatic check_model();
        logic [31:0] exp_gnt;
        exp_gnt = m_held ? (32'd1 << m_owner) : 32'd0;
        chk("gnt",       gnt,       exp_gnt);
        chk("lock_q",    lock_q,    {31'd0, m_held});
        chk("lock_qbar", lock_qbar, {31'd0, ~lock_q});
        chk("owner",     owner,     m_owner);
        chk("timeout",   timeout,   {31'd0, m_to});
        chk("onehot0",   ($countones(gnt) <= 1) ? 32'd1 : 32'd0, 32'd1);
        chk("lock_or",   lock_q,    {31'd0, |gnt});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(req, rel);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_gnt",   gnt,       32'd0);
        chk("rst_lock",  lock_q,    32'd0);
        chk("rst_qbar",  lock_qbar, 32'd1);
        chk("rst_owner", owner,     32'd0);
        chk("rst_to",    timeout,   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] rr_seq [5];
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        req    = '0;
        rel    = '0;
        model_reset();

        do_reset();

        // Single request, release three edges later.
        req = 4'b0100;
        tick();
        chk("single_gnt",   gnt,   32'h4);
        chk("single_owner", owner, 32'd2);
        req = 4'b0000;
        tick();
        tick();
        rel = 4'b0100;
        tick();
        chk("single_rel", gnt, 32'h0);
        rel = 4'b0000;
        tick();
        chk("single_gap", lock_q, 32'd0);
        tick();

        // Round robin from reset with every requester asking.
        do_reset();
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("rr_gnt", gnt, {28'd0, rr_seq[s]});
            rel = rr_seq[s];
            tick();
            chk("rr_rel", gnt, 32'h0);
            rel = 4'b0000;
            tick();
            chk("rr_gap", gnt, 32'h0);
        end

        // Watchdog: grant to requester 1 and never release.
        do_reset();
        req = 4'b0010;
        tick();
        chk("to_grant", gnt, 32'h2);
        req = 4'b0011;
        for (int c = 1; c < TIMEOUT; c++) begin
            tick();
            chk("to_hold", gnt, 32'h2);
            chk("to_nopulse", timeout, 32'd0);
        end
        tick();
        chk("to_drop", gnt, 32'h0);
        chk("to_pulse", timeout, 32'd1);
        tick();
        chk("to_pulse_end", timeout, 32'd0);
        tick();
        chk("to_next", gnt, 32'h1);

        // Non-owner release is ignored; release beats a simultaneous re-request.
        rel = 4'b0001;
        tick();
        rel = 4'b0000;
        req = 4'b0010;
        tick();
        tick();
        chk("no_owner1", owner, 32'd1);
        rel = 4'b0001;
        tick();
        chk("nonowner_rel", gnt, 32'h2);
        rel = 4'b0010;
        req = 4'b1010;
        tick();
        chk("simul_rel", gnt, 32'h0);
        rel = 4'b0000;
        tick();
        tick();
        chk("simul_next", gnt, 32'h8);
        rel = 4'b1000;
        tick();
        rel = 4'b0000;
        tick();
        tick();
        chk("simul_after", gnt, 32'h2);

        // Asynchronous reset while the lock is held, then re-arbitrate.
        tick();
        do_reset();
        req = 4'b1111;
        tick();
        chk("post_rst_gnt", gnt, 32'h1);

        // Random traffic with sparse release bursts.
        do_reset();
        for (int k = 0; k < 10000; k++) begin
            req = N'($urandom_range(0, (1 << N) - 1));
            rel = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_lock_arbiter.md
# sr_lock_arbiter

- Round-robin mutual-exclusion arbiter that shares one lock flag between `N` requesters.
- The lock flag is a registered set/reset pair: the grant event sets it and the release or timeout event resets it.
- A hold-time watchdog forcibly releases an owner that keeps the lock too long.
- It sits in front of the shared SR-flag resource and is the only block allowed to drive its set/reset.

## Interface
- `N`, 4, number of requesters (2–16).
- `TIMEOUT`, 16, maximum number of cycles `gnt` may stay high for one ownership (≥2).
- `clk`  input  1  rising-edge clock; the only clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  N  per-requester lock request, level-sensitive.
- `rel`  input  N  per-requester release; only the bit of the current owner is honoured.
- `gnt`  output  N  one-hot grant, registered; all zero when unlocked.
- `lock_q`  output  1  lock flag; 1 = held.
- `lock_qbar`  output  1  always the complement of `lock_q`, including during reset.
- `owner`  output  clog2(N)  index of the current owner; holds its last value when unlocked.
- `timeout`  output  1  one-cycle pulse on forced release.

## Operation
- Reset (asynchronous, while `rst_n`=0):
  - `gnt`=0, `lock_q`=0, `lock_qbar`=1, `owner`=0, `timeout`=0.
  - FSM goes to IDLE.
  - Round-robin pointer = N-1, so requester 0 has highest priority after reset.
  - Hold counter = 0.
- FSM has three states: IDLE, HELD, GAP.
- IDLE:
  - If `req` is nonzero, pick the first set bit searching upward from pointer+1, wrapping modulo N.
  - On that edge: `gnt` becomes one-hot for the winner, `owner` becomes the winner, `lock_q`=1, counter=0, pointer=winner. Go to HELD.
  - If `req`=0, stay in IDLE.
- HELD:
  - If `rel[owner]`=1: clear `gnt`, set `lock_q`=0, go to GAP.
  - Else if counter==TIMEOUT-1: same clear, plus `timeout`=1 for exactly one cycle, go to GAP.
  - Otherwise counter increments.
  - `rel` bits of non-owners are ignored.
  - Dropping `req[owner]` does not release the lock; only `rel` or the timeout does.
- GAP: lasts exactly one cycle with the lock reset; go to IDLE. `req` is not arbitrated in GAP.
- Priority: because the pointer equals the last owner, a requester that is re-requesting gets lowest priority in the next arbitration.
- `rel[owner]`=1 together with `req[owner]`=1 in the same cycle: release wins. The requester competes again from IDLE at lowest priority.
- `req` bits that change during HELD or GAP have no effect until IDLE.
- Counter width is clog2(TIMEOUT). It never wraps, because it is cleared on every grant.

## Timing
- Grant latency: a `req` bit sampled at rising edge k while in IDLE gives `gnt`/`lock_q` high after edge k.
- Release latency: `rel[owner]` sampled at edge k gives `gnt`=0 and `lock_q`=0 after edge k.
  - GAP occupies the cycle after edge k.
  - The earliest next grant appears after edge k+2.
- Maximum ownership: `gnt` is high for at most TIMEOUT cycles.
  - `timeout` is high for the single cycle following the forced-release edge, aligned with the first GAP cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset mid-HELD: outputs take their reset values immediately (asynchronously), without waiting for `clk`.
  - After `rst_n` deasserts, the first arbitration happens at the first rising edge with `req`≠0.
- `lock_q` and `lock_qbar` are never both 1 and never both 0 at any sampled edge.

## Test plan
- Reset: drive `rst_n`=0 mid-HELD between clock edges.
  - Expect `gnt`=0000, `lock_q`=0, `lock_qbar`=1, `owner`=0 immediately.
  - After release of reset, `req`=1111 → `gnt`=0001 one edge later.
- Single request: `req`=0100 at edge k → `gnt`=0100, `owner`=2 after k. `rel`=0100 at edge k+3 → `gnt`=0 after k+3, GAP, IDLE.
- Round robin: `req`=1111 held, each owner releases one cycle after its grant → grant order 0001, 0010, 0100, 1000, 0001, each separated by one GAP cycle.
- Timeout with TIMEOUT=16: grant 0010 and never release.
  - Expect `gnt` high exactly 16 cycles, `timeout`=1 for one cycle, then `gnt`=0.
  - With `req`=0011 still asserted, the next grant is 0001.
- Non-owner release and simultaneous events:
  - Owner=1 with `rel`=0001 → no effect.
  - `rel`=0010 together with `req`=0010|1000 → release. Next grant is 1000; requester 1 is served after requester 3.
- Complement check: over random `req`/`rel` for 10,000 cycles, confirm all of the following at every edge:
  - `lock_qbar` = ~`lock_q`.
  - `gnt` is one-hot or zero.
  - `lock_q` = OR(`gnt`).
